opb_stage: RTL and testbench

Parametrised ALU operand-B select and pipeline register for the pipelined datapath. It chooses between the register-file value, an extended immediate, and up to NFWD forwarded results. It registers the chosen operand into the ID/EX boundary, with stall, flush and valid tracking. It replaces the single-cycle two-way qb/imm select and sits between the register file / immediate extender and the ALU B input.

---
 rtl/opb_stage.sv | 119 +++++++++++
 tb/tb_opb_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/opb_stage.sv
// ALU operand-B select (qb / extended immediate / forwarded result) and ID/EX pipeline register.
// Forwarding and the fwd_hits counter are built only when OPB_FWD_EN is defined.
module opb_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NFWD  = 2,
  parameter int unsigned RW    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      qb,
  input  logic [RW-1:0]         rb,
  input  logic [15:0]           imm16,
  input  logic                  aluimm,
  input  logic [1:0]            immmode,
  input  logic [NFWD-1:0]       fwd_we,
  input  logic [NFWD*RW-1:0]    fwd_rn,
  input  logic [NFWD*WIDTH-1:0] fwd_data,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      b,
  output logic [1:0]            b_src,
  output logic [15:0]           fwd_hits
);

  typedef enum logic [1:0] {
    SRC_QB  = 2'd0,
    SRC_IMM = 2'd1,
    SRC_FWD = 2'd2,
    SRC_RSV = 2'd3
  } src_e;

  logic [WIDTH-1:0] ext_sign, ext_zero, ext_lui, ext_imm;
  logic [WIDTH-1:0] sel_val;
  src_e             sel_tag;
  logic             fwd_hit;
  logic [WIDTH-1:0] fwd_val;
  logic             valid_q;
  logic [WIDTH-1:0] b_q;
  src_e             src_q;

  always_comb begin
    ext_sign = {{(WIDTH-16){imm16[15]}}, imm16};
    ext_zero = {{(WIDTH-16){1'b0}}, imm16};
    // Shifting the zero-extended value covers both truncation and zero-padding of lui.
    ext_lui  = ext_zero << 16;
    case (immmode)
      2'b01:   ext_imm = ext_zero;
      2'b10:   ext_imm = ext_lui;
      default: ext_imm = ext_sign;
    endcase
  end

`ifdef OPB_FWD_EN
  always_comb begin
    fwd_hit = 1'b0;
    fwd_val = '0;
    for (int unsigned i = 0; i < NFWD; i++) begin
      if (!fwd_hit && fwd_we[i] && (fwd_rn[i*RW +: RW] == rb) && (rb != '0)) begin
        fwd_hit = 1'b1;
        fwd_val = fwd_data[i*WIDTH +: WIDTH];
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_we, fwd_rn, fwd_data};
  assign fwd_hit    = 1'b0;
  assign fwd_val    = '0;
`endif

  always_comb begin
    sel_val = qb;
    sel_tag = SRC_QB;
    if (aluimm) begin
      sel_val = ext_imm;
      sel_tag = SRC_IMM;
    end else if (fwd_hit) begin
      sel_val = fwd_val;
      sel_tag = SRC_FWD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      b_q     <= '0;
      src_q   <= SRC_QB;
    end else if (flush) begin
      valid_q <= 1'b0;
      b_q     <= sel_val;
      src_q   <= sel_tag;
    end else if (!stall) begin
      valid_q <= in_valid;
      b_q     <= sel_val;
      src_q   <= sel_tag;
    end
  end

`ifdef OPB_FWD_EN
  logic [15:0] hits_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      hits_q <= '0;
    end else if (!flush && !stall && in_valid && (sel_tag == SRC_FWD) && (hits_q != '1)) begin
      hits_q <= hits_q + 16'd1;
    end
  end
  assign fwd_hits = hits_q;
`else
  assign fwd_hits = '0;
`endif

  assign out_valid = valid_q;
  assign b         = b_q;
  assign b_src     = src_q;

endmodule

// File: tb/tb_opb_stage.sv
// Self-checking bench for opb_stage: directed scenarios plus randomized traffic against a spec-level model.
module tb_opb_stage;

  localparam int unsigned W  = 32;
  localparam int unsigned NF = 2;
  localparam int unsigned R  = 5;

  logic            clk = 1'b0;
  logic            rst, in_valid, aluimm, stall, flush;
  logic [W-1:0]    qb;
  logic [R-1:0]    rb;
  logic [15:0]     imm16;
  logic [1:0]      immmode;
  logic [NF-1:0]   fwd_we;
  logic [NF*R-1:0] fwd_rn;
  logic [NF*W-1:0] fwd_data;
  logic            out_valid;
  logic [W-1:0]    b;
  logic [1:0]      b_src;
  logic [15:0]     fwd_hits;

  int ntests = 0;
  int nfail  = 0;

  logic        m_valid;
  logic [31:0] m_b;
  logic [1:0]  m_src;
  int          m_hits;

  opb_stage #(.WIDTH(W), .NFWD(NF), .RW(R)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .qb(qb), .rb(rb), .imm16(imm16),
    .aluimm(aluimm), .immmode(immmode), .fwd_we(fwd_we), .fwd_rn(fwd_rn),
    .fwd_data(fwd_data), .stall(stall), .flush(flush), .out_valid(out_valid),
    .b(b), .b_src(b_src), .fwd_hits(fwd_hits)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Spec-level operand choice: immediate first, then the first matching forward source, else qb.
  task automatic model_sel(output logic [31:0] v, output logic [1:0] t);
    logic [31:0] imm;
    imm = 32'(imm16);
    if (immmode == 2'b01)      v = imm;
    else if (immmode == 2'b10) v = imm * 32'd65536;
    else                       v = (imm16 >= 16'h8000) ? imm + 32'hFFFF_0000 : imm;
    t = 2'd1;
    if (!aluimm) begin
      v = qb;
      t = 2'd0;
`ifdef OPB_FWD_EN
      if (rb != 0) begin
        for (int i = 0; i < NF; i++) begin
          if (t == 2'd0 && fwd_we[i] && fwd_rn[i*R +: R] == rb) begin
            v = fwd_data[i*W +: W];
            t = 2'd2;
          end
        end
      end
`endif
    end
  endtask

  task automatic cycle(input bit do_check);
    logic [31:0] v;
    logic [1:0]  t;
    model_sel(v, t);
    if (rst) begin
      m_valid = 1'b0; m_b = '0; m_src = '0; m_hits = 0;
    end else if (flush) begin
      m_valid = 1'b0; m_b = v; m_src = t;
    end else if (!stall) begin
      m_valid = in_valid; m_b = v; m_src = t;
      if (in_valid && t == 2'd2 && m_hits < 65535) m_hits++;
    end
    @(posedge clk);
    #1;
    if (do_check) begin
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("b", b, m_b);
      check("b_src", 32'(b_src), 32'(m_src));
      check("fwd_hits", 32'(fwd_hits), 32'(m_hits));
    end
  endtask

  task automatic randomize_inputs();
    in_valid = 1'($urandom);
    qb       = $urandom;
    rb       = R'($urandom_range(0, 7));
    imm16    = 16'($urandom);
    aluimm   = ($urandom_range(0, 3) == 0);
    immmode  = 2'($urandom);
    fwd_we   = NF'($urandom);
    fwd_rn   = {R'($urandom_range(0, 7)), R'($urandom_range(0, 7))};
    fwd_data = {$urandom, $urandom};
    stall    = ($urandom_range(0, 5) == 0);
    flush    = ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    logic [31:0] imm_exp [4];
    imm_exp[0] = 32'hFFFF_8001; imm_exp[1] = 32'h0000_8001;
    imm_exp[2] = 32'h8001_0000; imm_exp[3] = 32'hFFFF_8001;

    // Reset with random inputs
    randomize_inputs();
    rst = 1'b1;
    cycle(1'b1);
    randomize_inputs();
    cycle(1'b1);
    check("rst_b", b, 32'h0);
    check("rst_hits", 32'(fwd_hits), 32'h0);

    // First capture from qb
    rst = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b1; aluimm = 1'b0;
    qb = 32'h1234_5678; rb = 5'd3; fwd_we = '0;
    cycle(1'b1);
    check("first_b", b, 32'h1234_5678);
    check("first_valid", 32'(out_valid), 32'd1);

    // Immediate modes, forwarding present but ignored
    imm16 = 16'h8001; aluimm = 1'b1; rb = 5'd5; fwd_we = 2'b11;
    fwd_rn = {5'd5, 5'd5}; fwd_data = {32'h0000_BBBB, 32'h0000_AAAA};
    for (int m = 0; m < 4; m++) begin
      immmode = 2'(m);
      cycle(1'b1);
      check("imm_b", b, imm_exp[m]);
      check("imm_src", 32'(b_src), 32'd1);
    end

    // Forward priority and rb=0
    rst = 1'b1; cycle(1'b1); rst = 1'b0;
    aluimm = 1'b0; immmode = 2'b00; qb = 32'hCAFE_0001;
    cycle(1'b1);
`ifdef OPB_FWD_EN
    check("fwd_b", b, 32'h0000_AAAA);
    check("fwd_src", 32'(b_src), 32'd2);
    check("fwd_hits1", 32'(fwd_hits), 32'd1);
`else
    check("fwd_b", b, 32'hCAFE_0001);
    check("fwd_src", 32'(b_src), 32'd0);
    check("fwd_hits1", 32'(fwd_hits), 32'd0);
`endif
    rb = 5'd0; fwd_rn = '0;
    cycle(1'b1);
    check("r0_b", b, 32'hCAFE_0001);
    check("r0_src", 32'(b_src), 32'd0);

    // Stall holds, flush beats stall
    fwd_we = '0; qb = 32'h11;
    cycle(1'b1);
    stall = 1'b1; qb = 32'h22;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1);
      check("stall_b", b, 32'h11);
      check("stall_valid", 32'(out_valid), 32'd1);
    end
    flush = 1'b1;
    cycle(1'b1);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_b", b, 32'h22);
    stall = 1'b0; flush = 1'b0;

    // Randomized traffic with occasional reset
    for (int n = 0; n < 400; n++) begin
      randomize_inputs();
      rst = ($urandom_range(0, 49) == 0);
      cycle(1'b1);
    end

    // Counter saturation
    rst = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b1; aluimm = 1'b0;
    rb = 5'd5; fwd_we = 2'b01; fwd_rn = {5'd0, 5'd5}; fwd_data = {32'h0, 32'h5A5A};
    for (int n = 0; n < 65536; n++) cycle(1'b0);
    cycle(1'b1);
`ifdef OPB_FWD_EN
    check("sat_hits", 32'(fwd_hits), 32'h0000_FFFF);
`else
    check("sat_hits", 32'(fwd_hits), 32'h0);
`endif
    cycle(1'b1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
